// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 32-point FFT datapath.
// Provides point count, index width, word widths and bit reversal.
package fft_pkg;

    localparam int P_POINTS    = 32;
    localparam int P_LOG2      = 5;
    localparam int P_REAL_BITS = 15;
    localparam int P_WORD_BITS = 2 * P_REAL_BITS;

    function automatic logic [P_LOG2-1:0] bitrev5(
        input logic [P_LOG2-1:0] k
    );
        return {k[0], k[1], k[2], k[3], k[4]};
    endfunction

endpackage

// File: rtl/fft_frame_serializer_if.sv
// Frame-in / word-out handshake bundle of the FFT output serializer.
// master: upstream/downstream side; slave: the serializer itself.
interface fft_frame_serializer_if
    import fft_pkg::*;
#(
    parameter int p_wordBits = P_WORD_BITS
);

    logic                           i_valid;
    logic                           o_ready;
    logic [P_POINTS*p_wordBits-1:0] i_frame;
    logic                           o_valid;
    logic                           i_ready;
    logic [p_wordBits-1:0]          o_data;
    logic [P_LOG2-1:0]              o_index;
    logic                           o_last;
    logic                           o_overflow;

    modport master (
        output i_valid, i_frame, i_ready,
        input  o_ready, o_valid, o_data, o_index, o_last, o_overflow
    );

    modport slave (
        input  i_valid, i_frame, i_ready,
        output o_ready, o_valid, o_data, o_index, o_last, o_overflow
    );

endinterface

// File: rtl/fft_frame_bank.sv
// One 32-word frame buffer: all lanes written at once, indexed comb read.
// Ports: CLK, we (write all lanes), wdata (32 packed words), raddr, rdata.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int p_wordBits = P_WORD_BITS
) (
    input  logic                           CLK,
    input  logic                           we,
    input  logic [P_POINTS*p_wordBits-1:0] wdata,
    input  logic [P_LOG2-1:0]              raddr,
    output logic [p_wordBits-1:0]          rdata
);

    logic [p_wordBits-1:0] mem [P_POINTS];

    // Data storage only; contents are qualified by the frame count upstream.
    always_ff @(posedge CLK) begin
        if (we) begin
            for (int k = 0; k < P_POINTS; k++) begin
                mem[k] <= wdata[k*p_wordBits +: p_wordBits];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_frame_serializer.sv
// Double-buffered FFT frame capture streaming one complex word per cycle.
// Ports: CLK, RST (async active-low), bus (slave handshake bundle).
module fft_frame_serializer
    import fft_pkg::*;
#(
    parameter int p_realBits   = P_REAL_BITS,
    parameter int p_wordBits   = 2 * p_realBits,
    parameter bit p_bitReverse = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    fft_frame_serializer_if.slave bus
);

    localparam logic [P_LOG2-1:0] LAST_IDX = P_LOG2'(P_POINTS - 1);

    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            cnt;
    logic [P_LOG2-1:0]     idx;
    logic                  overflow;

    logic                  ready;
    logic                  valid;
    logic                  accept;
    logic                  drain;
    logic                  final_drain;
    logic [P_LOG2-1:0]     raddr;
    logic [p_wordBits-1:0] rdata0;
    logic [p_wordBits-1:0] rdata1;

    // Ready depends only on registered count: no ready-through on drain.
    assign ready       = (cnt < 2'd2);
    assign valid       = (cnt != 2'd0);
    assign accept      = bus.i_valid && ready;
    assign drain       = valid && bus.i_ready;
    assign final_drain = drain && (idx == LAST_IDX);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cnt      <= 2'd0;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (drain) begin
                idx <= idx + 1'b1;
            end
            if (final_drain) begin
                rd_ptr <= ~rd_ptr;
            end
            if (accept && !final_drain) begin
                cnt <= cnt + 2'd1;
            end else if (!accept && final_drain) begin
                cnt <= cnt - 2'd1;
            end
            if (bus.i_valid && !ready) begin
                overflow <= 1'b1;
            end
        end
    end

    assign raddr = p_bitReverse ? bitrev5(idx) : idx;

    fft_frame_bank #(
        .p_wordBits (p_wordBits)
    ) u_bank0 (
        .CLK   (CLK),
        .we    (accept && !wr_ptr),
        .wdata (bus.i_frame),
        .raddr (raddr),
        .rdata (rdata0)
    );

    fft_frame_bank #(
        .p_wordBits (p_wordBits)
    ) u_bank1 (
        .CLK   (CLK),
        .we    (accept && wr_ptr),
        .wdata (bus.i_frame),
        .raddr (raddr),
        .rdata (rdata1)
    );

    assign bus.o_ready    = ready;
    assign bus.o_valid    = valid;
    assign bus.o_data     = valid ? (rd_ptr ? rdata1 : rdata0) : '0;
    assign bus.o_index    = idx;
    assign bus.o_last     = valid && (idx == LAST_IDX);
    assign bus.o_overflow = overflow;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Scoreboard bench for fft_frame_serializer, bit-reversed and natural order.
// Ports: none; drives two DUT instances with identical traffic.
module tb_fft_frame_serializer;

    localparam int W = 30;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic [32*W-1:0] i_frame = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [35:0] q_a[$];
    logic [35:0] q_b[$];

    fft_frame_serializer_if #(.p_wordBits(W)) bus_a ();
    fft_frame_serializer_if #(.p_wordBits(W)) bus_b ();

    assign bus_a.i_valid = i_valid;
    assign bus_a.i_ready = i_ready;
    assign bus_a.i_frame = i_frame;
    assign bus_b.i_valid = i_valid;
    assign bus_b.i_ready = i_ready;
    assign bus_b.i_frame = i_frame;

    fft_frame_serializer #(
        .p_realBits   (15),
        .p_wordBits   (W),
        .p_bitReverse (1'b1)
    ) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a)
    );

    fft_frame_serializer #(
        .p_realBits   (15),
        .p_wordBits   (W),
        .p_bitReverse (1'b0)
    ) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_b)
    );

    always #5 CLK = ~CLK;

    function automatic int rev5(input int k);
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (4 - b));
        end
        return r;
    endfunction

    function automatic logic [W-1:0] lane(input int base, input int k);
        logic [14:0] re;
        logic [14:0] im;
        re = 15'(base + k);
        im = 15'(base + 100 + k);
        return {re, im};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Offer one frame; if accepted, queue its expected output stream.
    task automatic send(input int base, input bit exp_ready);
        for (int k = 0; k < 32; k++) begin
            i_frame[k*W +: W] = lane(base, k);
        end
        i_valid = 1'b1;
        chk("o_ready_at_offer", 64'(bus_a.o_ready), 64'(exp_ready));
        if (exp_ready) begin
            for (int i = 0; i < 32; i++) begin
                q_a.push_back({5'(i), lane(base, rev5(i)), i == 31});
                q_b.push_back({5'(i), lane(base, i), i == 31});
            end
        end
        @(posedge CLK);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_idx(input int target);
        for (int c = 0; c < 200; c++) begin
            @(posedge CLK);
            #1;
            if (bus_a.o_valid && 32'(bus_a.o_index) == target) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL wait_idx: index %0d not reached, got %0d",
                 target, bus_a.o_index);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300; c++) begin
            @(posedge CLK);
            #1;
            if (!bus_a.o_valid && !bus_b.o_valid) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL wait_idle: o_valid still %0b, required 0",
                 bus_a.o_valid);
    endtask

    always @(negedge CLK) begin
        if (bus_a.o_valid && bus_a.i_ready) begin
            if (q_a.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL stream_a: got word idx %0d %0h, required none",
                         bus_a.o_index, bus_a.o_data);
            end else begin
                chk("stream_a",
                    64'({bus_a.o_index, bus_a.o_data, bus_a.o_last}),
                    64'(q_a.pop_front()));
            end
        end
        if (bus_b.o_valid && bus_b.i_ready) begin
            if (q_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL stream_b: got word idx %0d %0h, required none",
                         bus_b.o_index, bus_b.o_data);
            end else begin
                chk("stream_b",
                    64'({bus_b.o_index, bus_b.o_data, bus_b.o_last}),
                    64'(q_b.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit, got hang, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset values
        #2;
        chk("rst_o_ready", 64'(bus_a.o_ready), 64'd1);
        chk("rst_o_valid", 64'(bus_a.o_valid), 64'd0);
        chk("rst_o_data", 64'(bus_a.o_data), 64'd0);
        chk("rst_o_index", 64'(bus_a.o_index), 64'd0);
        chk("rst_o_last", 64'(bus_a.o_last), 64'd0);
        chk("rst_o_overflow", 64'(bus_a.o_overflow), 64'd0);
        chk("rst_b_o_valid", 64'(bus_b.o_valid), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        i_ready = 1'b1;

        // Single frame, latency and hand-computed words
        send(0, 1'b1);
        @(negedge CLK);
        chk("lat_valid", 64'(bus_a.o_valid), 64'd1);
        chk("lat_index", 64'(bus_a.o_index), 64'd0);
        @(negedge CLK);
        chk("rev_idx1", 64'(bus_a.o_data), 64'({15'd16, 15'd116}));
        chk("nat_idx1", 64'(bus_b.o_data), 64'({15'd1, 15'd101}));
        repeat (30) @(negedge CLK);
        chk("rev_idx31", 64'({bus_a.o_index, bus_a.o_data, bus_a.o_last}),
            64'({5'd31, 15'd31, 15'd131, 1'b1}));
        @(negedge CLK);
        chk("done_valid", 64'(bus_a.o_valid), 64'd0);
        wait_idle();

        // Three frames back to back: third refused
        send(200, 1'b1);
        send(300, 1'b1);
        send(400, 1'b0);
        chk("overflow_set", 64'(bus_a.o_overflow), 64'd1);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (!bus_a.o_valid) break;
            n++;
        end
        chk("no_gap_words", 64'(n), 64'd62);
        chk("overflow_sticky", 64'(bus_a.o_overflow), 64'd1);
        wait_idle();

        // Backpressure at index 7
        send(500, 1'b1);
        wait_idx(7);
        i_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("hold_index", 64'(bus_a.o_index), 64'd7);
            chk("hold_data_a", 64'(bus_a.o_data), 64'(lane(500, 28)));
            chk("hold_data_b", 64'(bus_b.o_data), 64'(lane(500, 7)));
        end
        @(posedge CLK);
        #1;
        i_ready = 1'b1;
        wait_idle();

        // Final drain and accept on the same edge
        send(600, 1'b1);
        wait_idx(31);
        send(700, 1'b1);
        chk("swap_ready", 64'(bus_a.o_ready), 64'd1);
        chk("swap_valid", 64'(bus_a.o_valid), 64'd1);
        chk("swap_index", 64'(bus_a.o_index), 64'd0);
        wait_idle();

        // Reset in the middle of a two-frame backlog
        send(800, 1'b1);
        send(900, 1'b1);
        wait_idx(12);
        RST = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus_a.o_valid), 64'd0);
        chk("mid_rst_ready", 64'(bus_a.o_ready), 64'd1);
        chk("mid_rst_overflow", 64'(bus_a.o_overflow), 64'd0);
        chk("mid_rst_data", 64'(bus_b.o_data), 64'd0);
        q_a.delete();
        q_b.delete();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        send(1000, 1'b1);
        @(negedge CLK);
        chk("post_rst_index", 64'(bus_a.o_index), 64'd0);
        chk("post_rst_data", 64'(bus_a.o_data), 64'(lane(1000, 0)));
        wait_idle();
        chk("queue_a_empty", 64'(q_a.size()), 64'd0);
        chk("queue_b_empty", 64'(q_b.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
